// File: rtl/trace_pkg.sv
// Shared types and widths for the writeback trace buffer.
package trace_pkg;

    localparam int TRACE_W    = 73;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_rec_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x W storage with one synchronous write port and one asynchronous read port.
module sync_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 73,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    // Contents are deliberately not reset; readers must qualify with occupancy.
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Buffers the CPU writeback debug trace and drains it over a valid/ready port,
// counting records lost when the consumer falls behind.
module wb_trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int SKIP_R0 = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [31:0]               debug_wb_pc,
    input  logic [3:0]                debug_wb_rf_wen,
    input  logic [4:0]                debug_wb_rf_wnum,
    input  logic [31:0]               debug_wb_rf_wdata,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [31:0]               trace_pc,
    output logic [3:0]                trace_wen,
    output logic [4:0]                trace_wnum,
    output logic [31:0]               trace_wdata,
    output logic [$clog2(DEPTH):0]    trace_count,
    output logic                      trace_overflow,
    output logic [DROP_CNT_W-1:0]     trace_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_cap;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    trace_rec_t            w_wr_rec;
    trace_rec_t            w_head;
    logic [TRACE_W-1:0]    w_rd_data;

    assign w_cap  = (debug_wb_rf_wen != 4'd0) &&
                    !((SKIP_R0 != 0) && (debug_wb_rf_wnum == 5'd0));
    assign w_full = (r_count == FULL_CNT);
    assign trace_valid = (r_count != '0);
    assign w_pop  = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && w_full && !w_pop;

    assign w_wr_rec = '{pc:    debug_wb_pc,
                        wen:   debug_wb_rf_wen,
                        wnum:  debug_wb_rf_wnum,
                        wdata: debug_wb_rf_wdata};

    sync_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (TRACE_W),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_rec),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign w_head = trace_rec_t'(w_rd_data);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Storage is unreset, so the head fields are forced to zero while empty.
    assign trace_pc       = trace_valid ? w_head.pc    : 32'd0;
    assign trace_wen      = trace_valid ? w_head.wen   : 4'd0;
    assign trace_wnum     = trace_valid ? w_head.wnum  : 5'd0;
    assign trace_wdata    = trace_valid ? w_head.wdata : 32'd0;
    assign trace_count    = r_count;
    assign trace_overflow = r_overflow;
    assign trace_drop_cnt = r_drop_cnt;

endmodule
